// File: rtl/adc_scan_sched.sv
// adc_scan_sched: round-robin ADC0809 scan scheduler feeding a byte-wide TX path.
// Each enabled channel is converted and sent as a {HDR_TAG,ch} header byte, then the data byte.
//
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   scan_en         level, 1 = keep scanning
//   ch_mask         per-channel enable, bit n = channel n
//   eoc, adc_input  converter end-of-conversion (asynchronous) and data bus
//   adc_clk         free-running converter clock
//   ale, start, oe  converter strobes
//   addr            converter channel select
//   tx_data         byte offered to serial TX
//   tx_valid        tx_data is valid
//   tx_ready        serial TX can accept a byte
//   busy            scheduler is not idle
//   timeout_err     one-cycle pulse when an eoc wait times out

module adc_scan_sched #(
  parameter int unsigned ADC_DIV     = 25,
  parameter int unsigned PULSE_W     = 8,
  parameter int unsigned OE_W        = 4,
  parameter logic [15:0] EOC_TIMEOUT = 16'd50000,
  parameter logic [4:0]  HDR_TAG     = 5'b10100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [7:0] ch_mask,
  input  logic       eoc,
  input  logic [7:0] adc_input,
  output logic       adc_clk,
  output logic       ale,
  output logic       start,
  output logic       oe,
  output logic [2:0] addr,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned DW =
    (ADC_DIV > 1) ? $clog2(ADC_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST =
    DW'(ADC_DIV - 1);

  localparam logic [15:0] PW_LAST =
    16'(PULSE_W - 1);

  localparam logic [15:0] OE_LAST =
    16'(OE_W - 1);

  localparam logic [15:0] TO_LAST =
    EOC_TIMEOUT - 16'd1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_SETUP,
    S_ALE,
    S_START,
    S_WLO,
    S_WHI,
    S_READ,
    S_HDR,
    S_DAT,
    S_NEXT
  } state_t;

  state_t        state_q;

  logic [DW-1:0] div_q;
  logic          aclk_q;

  logic          eoc_s1_q;
  logic          eoc_s2_q;

  logic [2:0]    ptr_q;
  logic [2:0]    addr_q;
  logic [2:0]    sel_d;
  logic [15:0]   cnt_q;
  logic [7:0]    data_q;

  logic          ale_q;
  logic          start_q;
  logic          oe_q;
  logic          txv_q;
  logic [7:0]    txd_q;
  logic          busy_q;
  logic          to_q;

  // Converter clock divider, runs regardless of scheduler state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      aclk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q  <= '0;
      aclk_q <= ~aclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eoc_s1_q <= 1'b0;
      eoc_s2_q <= 1'b0;
    end else begin
      eoc_s1_q <= eoc;
      eoc_s2_q <= eoc_s1_q;
    end
  end

  // Search upward from ptr+1 with wrap. Offset 8 wraps to the
  // current channel, so it is taken only if nothing else is set.
  // Iterating downward lets the nearest candidate win.
  always_comb begin
    sel_d = ptr_q;
    for (int i = 8; i >= 1; i--) begin
      if (ch_mask[ptr_q + 3'(i)]) begin
        sel_d = ptr_q + 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd7;
      addr_q  <= 3'd0;
      cnt_q   <= 16'd0;
      data_q  <= 8'h00;
      ale_q   <= 1'b0;
      start_q <= 1'b0;
      oe_q    <= 1'b0;
      txv_q   <= 1'b0;
      txd_q   <= 8'h00;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (scan_en && (ch_mask != 8'h00)) begin
            state_q <= S_SEL;
            busy_q  <= 1'b1;
          end
        end

        S_SEL: begin
          if (ch_mask == 8'h00) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            addr_q  <= sel_d;
            ptr_q   <= sel_d;
            cnt_q   <= 16'd0;
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt_q == PW_LAST) begin
            cnt_q   <= 16'd0;
            ale_q   <= 1'b1;
            state_q <= S_ALE;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end

        S_ALE: begin
          if (cnt_q == PW_LAST) begin
            cnt_q   <= 16'd0;
            start_q <= 1'b1;
            state_q <= S_START;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end

        S_START: begin
          // ale overlaps start for exactly the first cycle.
          if (cnt_q == 16'd0) begin
            ale_q <= 1'b0;
          end
          if (cnt_q == PW_LAST) begin
            cnt_q   <= 16'd0;
            start_q <= 1'b0;
            state_q <= S_WLO;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end

        S_WLO: begin
          if (!eoc_s2_q) begin
            cnt_q   <= 16'd0;
            state_q <= S_WHI;
          end else if (cnt_q == TO_LAST) begin
            to_q    <= 1'b1;
            state_q <= S_NEXT;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end

        S_WHI: begin
          if (eoc_s2_q) begin
            cnt_q   <= 16'd0;
            oe_q    <= 1'b1;
            state_q <= S_READ;
          end else if (cnt_q == TO_LAST) begin
            to_q    <= 1'b1;
            state_q <= S_NEXT;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end

        S_READ: begin
          // Capture on the last oe cycle; oe drops with the capture.
          if (cnt_q == OE_LAST) begin
            data_q  <= adc_input;
            oe_q    <= 1'b0;
            txd_q   <= {HDR_TAG, addr_q};
            txv_q   <= 1'b1;
            state_q <= S_HDR;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end

        S_HDR: begin
          if (tx_ready) begin
            txd_q   <= data_q;
            state_q <= S_DAT;
          end
        end

        S_DAT: begin
          if (tx_ready) begin
            txv_q   <= 1'b0;
            state_q <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (scan_en) begin
            state_q <= S_SEL;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_clk     = aclk_q;
  assign ale         = ale_q;
  assign start       = start_q;
  assign oe          = oe_q;
  assign addr        = addr_q;
  assign tx_data     = txd_q;
  assign tx_valid    = txv_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;

endmodule

// File: doc/adc_scan_sched.md
Name: adc_scan_sched

Overview:
Multi-channel scan scheduler for the ADC0809-style converter and the serial transmitter.
- Walks the enabled analog channels in round-robin order and runs the converter handshake for each one: addr, ale, start, wait on eoc, then oe/read.
- Hands each result to the serial TX path as a two-byte frame (channel header, data) over a valid/ready handshake.
- Replaces the fixed single-channel ADC sequencing at the top level.

Parameters:
ADC_DIV, 25, clk cycles per adc_clk half-period (50 MHz -> 1 MHz adc_clk)
PULSE_W, 8, clk cycles each for ale and start high, and for address setup before ale
OE_W, 4, clk cycles oe held high before result capture
EOC_TIMEOUT, 16'd50000, clk cycles allowed in each eoc wait state before abort
HDR_TAG, 5'b10100, upper 5 bits of header byte

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
scan_en  input  1  level; 1 = run scanning
ch_mask  input  8  per-channel enable, bit n = channel n
eoc  input  1  converter end-of-conversion (asynchronous)
adc_input  input  8  converter data bus
adc_clk  output  1  converter clock
ale  output  1  address latch enable
start  output  1  conversion start
oe  output  1  converter output enable
addr  output  3  converter channel select
tx_data  output  8  byte to serial TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  serial TX can accept a byte
busy  output  1  1 whenever state != IDLE
timeout_err  output  1  one-clk pulse on eoc timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0: adc_clk=0, addr=3'd0, tx_data=8'h00.
  - FSM goes to IDLE; channel pointer = 7, so the first scan starts at the lowest enabled channel.
  - Reset mid-operation aborts immediately with no partial frame; tx_valid drops asynchronously.
- adc_clk:
  - Free-running divider, toggles every ADC_DIV clk cycles.
  - Independent of FSM state; runs out of reset.
- eoc:
  - Passed through a 2-flop synchronizer; the FSM uses only the synchronized copy.
- Next-channel select:
  - Next channel = first set bit of ch_mask searched from pointer+1 upward, wrapping 7 -> 0.
  - The current channel counts as a candidate last, so a single enabled channel repeats.
  - ch_mask is sampled only in IDLE and SEL.
- FSM:
  - IDLE: if scan_en=1 and ch_mask!=0 -> SEL; otherwise stay.
  - SEL: load addr and pointer with the selected channel; -> SETUP. If ch_mask became 0 -> IDLE.
  - SETUP: hold addr PULSE_W cycles -> ALE.
  - ALE: ale=1 for PULSE_W cycles -> START.
  - START: start=1 for PULSE_W cycles; ale stays 1 for the first cycle only -> WLO.
  - WLO: wait for synchronized eoc=0 -> WHI.
  - WHI: wait for synchronized eoc=1 -> READ.
  - Timeout (WLO and WHI): the wait counter resets on entry to each state. On reaching EOC_TIMEOUT: timeout_err pulses, no frame is sent, -> NEXT.
  - READ: oe=1 for OE_W cycles. Capture adc_input into a data register on the last oe cycle; oe drops the cycle after capture -> HDR.
  - HDR: tx_data={HDR_TAG,addr}, tx_valid=1. A transfer occurs on a cycle with tx_valid&tx_ready -> DAT.
  - DAT: tx_data=captured byte, tx_valid=1. On transfer -> NEXT.
  - NEXT: if scan_en=1 -> SEL, else -> IDLE.
- tx handshake:
  - tx_data is stable while tx_valid=1 and not yet accepted.
  - tx_valid deasserts in the cycle after the DAT transfer.
  - No combinational path from tx_ready to tx_valid.
- scan_en=0 mid-channel: the current channel completes in full (both bytes), then the FSM goes to IDLE.
- Only one of ale/start/oe is high at once, except the single ale/start overlap cycle.

Test Plan:
- ch_mask=8'h05, scan_en=1, tx_ready=1, converter model returns 8'h3C (ch0) and 8'hA7 (ch2) -> frames A0,3C then A2,A7 then A0,3C again; addr sequence 0,2,0.
- Only ch_mask=8'h80 set -> addr stays 7, every frame is A7,xx; the wrap search must not select channel 0.
- tx_ready held 0 for 100 cycles during HDR -> tx_valid=1, tx_data=A0 stable throughout; DAT follows only after tx_ready=1 for one cycle.
- eoc held high forever after start -> timeout_err pulses once after EOC_TIMEOUT cycles in WLO, no tx_valid; the next enabled channel is then scanned.
- scan_en dropped during WHI of ch3 -> both ch3 bytes are still sent, then busy=0 and the FSM stays in IDLE; ch_mask=0 with scan_en=1 -> busy stays 0.
- reset asserted during DAT with tx_valid=1 -> all outputs 0 immediately; after release the first frame is from the lowest enabled channel.
